irq_controller: RTL and testbench
=================================

# irq_controller

Machine-level interrupt source for the pipelined core. Synchronizes and latches an external interrupt line and generates a machine-timer interrupt, gates both with the CSR enable bits, and drives the `interrupt` request into the CSR register file. It holds each request until the CSR file reports the trap taken (`epc_taken`), then blocks new requests until `mret` retires. It also exports the live `mip` value.

## Interface
- `TMR_BASE`, default 2'b00: reserved timer-bus address offset; only 0 is supported.
- `clk` input 1: core clock; everything is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `ext_irq` input 1: asynchronous external interrupt line; the rising edge is significant.
- `mstatus_mie` input 1: mstatus bit 3, the global enable.
- `mie_meie` input 1: mie bit 11, the external enable.
- `mie_mtie` input 1: mie bit 7, the timer enable.
- `epc_taken` input 1: trap/return redirect from the CSR file.
- `is_mret` input 1: an mret is executing this cycle.
- `tmr_wr` input 1: timer register write strobe.
- `tmr_addr` input 2: timer register select. 0 = mtimecmp[31:0], 1 = mtimecmp[63:32], 2 = mtime[31:0], 3 = mtime[63:32].
- `tmr_wdata` input 32: timer write data.
- `tmr_rdata` output 32: combinational read of the register at `tmr_addr`.
- `interrupt` output 2: registered request to the CSR file. 2'b00 = none, 2'b01 = external, 2'b10 = timer; 2'b11 is never driven.
- `mip` output 32: bit 11 = ext_pending, bit 7 = timer_pending, all other bits 0.
- `in_handler` output 1: high from trap acceptance until mret.

## Operation
- **External path**
  - `ext_irq` passes through a 2-flop synchronizer, then rising-edge detection.
  - An edge sets `ext_pending`.
  - `ext_pending` clears when an external request is accepted.
  - If a new edge and the acceptance land in the same cycle, the set wins.
- **Timer path**
  - `mtime` is 64 bits and increments by 1 every cycle.
  - `timer_pending` = (mtime >= mtimecmp), unsigned 64-bit compare, level-sensitive. Software clears it by rewriting mtimecmp.
  - mtime wraps from 2^64-1 to 0.
  - A write to mtime lo or hi replaces that half and suppresses the increment for that cycle. The other half holds.
  - Writes to mtimecmp do not affect counting.
- **Eligibility and priority**
  - ext_ok = ext_pending & mie_meie & mstatus_mie.
  - tmr_ok = timer_pending & mie_mtie & mstatus_mie.
  - External has priority over timer.
- **Acceptance**: ack = epc_taken & ~is_mret, sampled only in state REQ.
- **FSM**
  - IDLE: if ext_ok, load `interrupt` = 01 and go to REQ. Else if tmr_ok, load 10 and go to REQ. Else stay.
  - REQ: hold `interrupt` stable regardless of enable changes. On ack: clear `interrupt` to 00, clear ext_pending if the code was 01, set `in_handler`, go to SERVICE.
  - SERVICE: no new requests. On is_mret: clear `in_handler`, go to IDLE.
  - is_mret seen in IDLE or REQ is ignored.

## Timing
- **Reset values**
  - State IDLE, `interrupt` = 0, `in_handler` = 0, ext_pending = 0, synchronizer flops 0.
  - mtime = 0 and mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so no spurious timer interrupt.
  - `mip` = 0.
  - Reset mid-request drops the request with no acknowledge needed.
- **External latency**: `ext_irq` sampled high at edge N → ext_pending high after edge N+2 → `interrupt` = 01 after edge N+3, if in IDLE and enabled.
- **Timer latency**: the compare becomes true at edge T → `interrupt` = 10 after edge T+1.
- **Request lifetime**: `interrupt` deasserts on the edge that samples ack. The earliest re-request is the cycle after the mret edge plus one IDLE evaluation edge.
- **Back-to-back interrupts**: at mret with both sources pending, external is issued first. The timer follows after the next mret.
- **Timer bus**: writes take effect at the edge; reads are combinational from the current registers.

## Configuration
- `IRQ_TIMER_EN` defined: mtime, mtimecmp, the comparator and the timer path are built as described.
- `IRQ_TIMER_EN` undefined:
  - The timer registers are removed and timer_pending is constant 0.
  - `tmr_rdata` reads 0 and `tmr_wr` is ignored.
  - `interrupt` never takes 10.
  - All `tmr_*` ports remain present.

## Test plan
- **External path**: reset, set enables 1, pulse `ext_irq` at cycle 5 → `interrupt` = 01 from cycle 8. Hold `epc_taken` low for 3 cycles → `interrupt` stays 01. Raise `epc_taken` → `interrupt` 00 and `in_handler` 1 next edge. `is_mret` → `in_handler` 0.
- **Timer path** (`IRQ_TIMER_EN` defined): write mtimecmp = 20 (lo 20, hi 0) → `mip`[7] rises when mtime reaches 20, and `interrupt` = 10 one edge later. Write mtimecmp hi = 1 → `mip`[7] drops.
- **Priority**: both pending and enabled → 01 first. After ack and mret → 10.
- **Gating**: `mstatus_mie` = 0 with an external edge → `mip`[11] = 1 and `interrupt` stays 00. Set `mstatus_mie` = 1 → `interrupt` = 01 next edge.
- **Boundaries**:
  - An `ext_irq` edge landing on the ack cycle leaves `mip`[11] = 1.
  - Write mtime = 2^64-1 → mtime reads 0 two cycles later.
  - Assert `reset` while in REQ → `interrupt` 00 and mtimecmp all-ones.

Source files
------------

// File: rtl/irq_controller_if.sv
// CSR-file and timer-bus signal bundle for irq_controller.
// The master side is the CSR file / core and the slave side is the interrupt controller.
interface irq_controller_if;
  logic        mstatus_mie;
  logic        mie_meie;
  logic        mie_mtie;
  logic        epc_taken;
  logic        is_mret;
  logic        tmr_wr;
  logic [1:0]  tmr_addr;
  logic [31:0] tmr_wdata;
  logic [31:0] tmr_rdata;
  logic [1:0]  interrupt;
  logic [31:0] mip;
  logic        in_handler;

  modport master (
    output mstatus_mie, mie_meie, mie_mtie, epc_taken, is_mret,
    output tmr_wr, tmr_addr, tmr_wdata,
    input  tmr_rdata, interrupt, mip, in_handler
  );

  modport slave (
    input  mstatus_mie, mie_meie, mie_mtie, epc_taken, is_mret,
    input  tmr_wr, tmr_addr, tmr_wdata,
    output tmr_rdata, interrupt, mip, in_handler
  );
endinterface

// File: rtl/irq_controller.sv
// Machine-level interrupt source: synchronized external line plus optional mtime/mtimecmp timer,
// gated by the CSR enables. The timer is built only when IRQ_TIMER_EN is defined.
module irq_controller #(
  parameter logic [1:0] TMR_BASE = 2'b00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_irq,
  irq_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  interrupt_r, interrupt_s;
  logic        in_handler_r, in_handler_s;
  logic        ext_clr_s;
  logic [1:0]  sync_r;
  logic        ext_prev_r;
  logic        ext_edge_s;
  logic        ext_pending_r;
  logic        timer_pending_s;
  logic        ext_ok_s;
  logic        tmr_ok_s;
  logic        ack_s;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r     <= 2'b00;
      ext_prev_r <= 1'b0;
    end else begin
      sync_r     <= {sync_r[0], ext_irq};
      ext_prev_r <= sync_r[1];
    end
  end

  assign ext_edge_s = sync_r[1] & ~ext_prev_r;

  // Pending flag: a fresh edge beats a simultaneous acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_pending_r <= 1'b0;
    end else if (ext_edge_s) begin
      ext_pending_r <= 1'b1;
    end else if (ext_clr_s) begin
      ext_pending_r <= 1'b0;
    end else begin
      ext_pending_r <= ext_pending_r;
    end
  end

`ifdef IRQ_TIMER_EN
  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic [1:0]  tmr_sel_s;

  assign tmr_sel_s = bus.tmr_addr - TMR_BASE;

  // Free-running counter; a write to either half replaces it and skips that cycle's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_r <= 64'd0;
    end else if (bus.tmr_wr && (tmr_sel_s == 2'd2)) begin
      mtime_r <= {mtime_r[63:32], bus.tmr_wdata};
    end else if (bus.tmr_wr && (tmr_sel_s == 2'd3)) begin
      mtime_r <= {bus.tmr_wdata, mtime_r[31:0]};
    end else begin
      mtime_r <= mtime_r + 64'd1;
    end
  end

  // Compare register resets to all-ones so nothing fires before software programs it
  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (bus.tmr_wr && (tmr_sel_s == 2'd0)) begin
      mtimecmp_r <= {mtimecmp_r[63:32], bus.tmr_wdata};
    end else if (bus.tmr_wr && (tmr_sel_s == 2'd1)) begin
      mtimecmp_r <= {bus.tmr_wdata, mtimecmp_r[31:0]};
    end else begin
      mtimecmp_r <= mtimecmp_r;
    end
  end

  assign timer_pending_s = (mtime_r >= mtimecmp_r);

  // Combinational register read
  always_comb begin
    bus.tmr_rdata = 32'd0;
    case (tmr_sel_s)
      2'd0:    bus.tmr_rdata = mtimecmp_r[31:0];
      2'd1:    bus.tmr_rdata = mtimecmp_r[63:32];
      2'd2:    bus.tmr_rdata = mtime_r[31:0];
      2'd3:    bus.tmr_rdata = mtime_r[63:32];
      default: bus.tmr_rdata = 32'd0;
    endcase
  end
`else
  logic tmr_unused_s;

  assign tmr_unused_s    = ^{bus.tmr_wr, bus.tmr_addr, bus.tmr_wdata, bus.mie_mtie, TMR_BASE};
  assign timer_pending_s = 1'b0;
  assign bus.tmr_rdata   = 32'd0;
`endif

  assign ext_ok_s = ext_pending_r & bus.mie_meie & bus.mstatus_mie;
`ifdef IRQ_TIMER_EN
  assign tmr_ok_s = timer_pending_s & bus.mie_mtie & bus.mstatus_mie;
`else
  assign tmr_ok_s = 1'b0;
`endif
  assign ack_s    = bus.epc_taken & ~bus.is_mret;

  // State and registered request outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      interrupt_r  <= 2'b00;
      in_handler_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      interrupt_r  <= interrupt_s;
      in_handler_r <= in_handler_s;
    end
  end

  // Next-state logic: request is frozen in REQ until the trap is taken
  always_comb begin
    state_s      = state_r;
    interrupt_s  = interrupt_r;
    in_handler_s = in_handler_r;
    ext_clr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ext_ok_s) begin
          interrupt_s = 2'b01;
          state_s     = ST_REQ;
        end else if (tmr_ok_s) begin
          interrupt_s = 2'b10;
          state_s     = ST_REQ;
        end else begin
          interrupt_s = 2'b00;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          interrupt_s  = 2'b00;
          ext_clr_s    = (interrupt_r == 2'b01);
          in_handler_s = 1'b1;
          state_s      = ST_SERVICE;
        end else begin
          interrupt_s = interrupt_r;
        end
      end
      ST_SERVICE: begin
        if (bus.is_mret) begin
          in_handler_s = 1'b0;
          state_s      = ST_IDLE;
        end else begin
          in_handler_s = 1'b1;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        interrupt_s  = 2'b00;
        in_handler_s = 1'b0;
      end
    endcase
  end

  assign bus.interrupt  = interrupt_r;
  assign bus.in_handler = in_handler_r;
  assign bus.mip        = {20'd0, ext_pending_r, 3'd0, timer_pending_s, 7'd0};

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them. Timer checks depend on IRQ_TIMER_EN.
module tb_irq_controller;

  localparam int SIG_INT  = 0;
  localparam int SIG_HAND = 1;
  localparam int SIG_MIP  = 2;
  localparam int SIG_RD   = 3;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  logic ext_irq;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  irq_controller_if bus ();

  irq_controller #(.TMR_BASE(2'b00)) dut (
    .clk     (clk),
    .reset   (reset),
    .ext_irq (ext_irq),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      SIG_INT:  return {30'd0, bus.interrupt};
      SIG_HAND: return {31'd0, bus.in_handler};
      SIG_MIP:  return bus.mip;
      default:  return bus.tmr_rdata;
    endcase
  endfunction

  // Monitor: compare every expectation tagged with the current cycle
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        logic [31:0] act;
        act = sample(sb_q[i].sig);
        checks = checks + 1;
        if (act !== sb_q[i].val) begin
          errors = errors + 1;
          $display("FAIL %s @cyc %0d: got %0h expected %0h", sb_q[i].name, cyc, act, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic push(input int c, input int sig, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = c;
    e.sig  = sig;
    e.val  = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    ext_irq         = 1'b0;
    bus.mstatus_mie = 1'b0;
    bus.mie_meie    = 1'b0;
    bus.mie_mtie    = 1'b0;
    bus.epc_taken   = 1'b0;
    bus.is_mret     = 1'b0;
    bus.tmr_wr      = 1'b0;
    bus.tmr_addr    = 2'd0;
    bus.tmr_wdata   = 32'd0;

    // Reset state
    push(2, SIG_INT,  32'd0, "rst_interrupt");
    push(2, SIG_HAND, 32'd0, "rst_in_handler");
    push(2, SIG_MIP,  32'd0, "rst_mip");
`ifdef IRQ_TIMER_EN
    push(2, SIG_RD, 32'hFFFF_FFFF, "rst_mtimecmp_lo");
    push(3, SIG_RD, 32'hFFFF_FFFF, "rst_mtimecmp_hi");
    push(4, SIG_RD, 32'd1,         "mtime_first_count");
`else
    push(2, SIG_RD, 32'd0, "rst_rdata0");
    push(3, SIG_RD, 32'd0, "rst_rdata1");
    push(4, SIG_RD, 32'd0, "rst_rdata2");
`endif
    wait_cyc(3);
    bus.tmr_addr = 2'd1;
    reset        = 1'b0;
    wait_cyc(4);
    bus.tmr_addr = 2'd2;
    wait_cyc(6);

    // External path: edge -> pending N+2 -> request N+3, hold, ack, mret
    bus.mstatus_mie = 1'b1;
    bus.mie_meie    = 1'b1;
    t = cyc;
    ext_irq = 1'b1;
    push(t + 2,  SIG_MIP,  32'h0,   "ext_mip_early");
    push(t + 3,  SIG_MIP,  32'h800, "ext_mip_set");
    push(t + 3,  SIG_INT,  32'd0,   "ext_int_not_yet");
    push(t + 4,  SIG_INT,  32'd1,   "ext_int_req");
    push(t + 6,  SIG_INT,  32'd1,   "ext_int_hold1");
    push(t + 7,  SIG_INT,  32'd1,   "ext_int_hold2");
    push(t + 8,  SIG_INT,  32'd0,   "ext_int_acked");
    push(t + 8,  SIG_HAND, 32'd1,   "ext_in_handler");
    push(t + 8,  SIG_MIP,  32'h0,   "ext_mip_cleared");
    push(t + 9,  SIG_HAND, 32'd1,   "ext_service_hold");
    push(t + 10, SIG_HAND, 32'd0,   "ext_mret_hand");
    push(t + 10, SIG_INT,  32'd0,   "ext_idle_int");
    wait_cyc(t + 1);  ext_irq = 1'b0;
    wait_cyc(t + 7);  bus.epc_taken = 1'b1;
    wait_cyc(t + 8);  bus.epc_taken = 1'b0;
    wait_cyc(t + 9);  bus.is_mret = 1'b1;
    wait_cyc(t + 10); bus.is_mret = 1'b0;
    wait_cyc(t + 12);

    // Gating by mstatus_mie, then an edge landing on the ack edge
    t = cyc;
    bus.mstatus_mie = 1'b0;
    ext_irq = 1'b1;
    push(t + 3,  SIG_MIP,  32'h800, "gate_mip");
    push(t + 5,  SIG_INT,  32'd0,   "gate_int_blocked1");
    push(t + 6,  SIG_INT,  32'd0,   "gate_int_blocked2");
    push(t + 7,  SIG_INT,  32'd1,   "gate_int_released");
    push(t + 9,  SIG_INT,  32'd1,   "edge_ack_int_before");
    push(t + 10, SIG_INT,  32'd0,   "edge_ack_int");
    push(t + 10, SIG_HAND, 32'd1,   "edge_ack_hand");
    push(t + 10, SIG_MIP,  32'h800, "edge_ack_mip_kept");
    push(t + 12, SIG_HAND, 32'd0,   "edge_ack_mret");
    push(t + 12, SIG_INT,  32'd0,   "edge_ack_int_idle");
    push(t + 13, SIG_INT,  32'd1,   "edge_ack_rereq");
    push(t + 14, SIG_MIP,  32'h0,   "edge_ack_mip_clr");
    wait_cyc(t + 1);  ext_irq = 1'b0;
    wait_cyc(t + 6);  bus.mstatus_mie = 1'b1;
    wait_cyc(t + 7);  ext_irq = 1'b1;
    wait_cyc(t + 8);  ext_irq = 1'b0;
    wait_cyc(t + 9);  bus.epc_taken = 1'b1;
    wait_cyc(t + 10); bus.epc_taken = 1'b0;
    wait_cyc(t + 11); bus.is_mret = 1'b1;
    wait_cyc(t + 12); bus.is_mret = 1'b0;
    wait_cyc(t + 13); bus.epc_taken = 1'b1;
    wait_cyc(t + 14); bus.epc_taken = 1'b0;
    wait_cyc(t + 15); bus.is_mret = 1'b1;
    wait_cyc(t + 16); bus.is_mret = 1'b0;
    wait_cyc(t + 18);

`ifdef IRQ_TIMER_EN
    // Timer: mtime := 0, mtimecmp := 20, request one edge after the compare
    t = cyc;
    bus.mie_mtie  = 1'b1;
    bus.tmr_wr    = 1'b1;
    bus.tmr_addr  = 2'd2;
    bus.tmr_wdata = 32'd0;
    push(t + 3,  SIG_RD,  32'd2,  "tmr_mtime_2");
    push(t + 10, SIG_RD,  32'd9,  "tmr_mtime_9");
    push(t + 20, SIG_MIP, 32'h0,  "tmr_mip_before");
    push(t + 21, SIG_MIP, 32'h80, "tmr_mip_set");
    push(t + 21, SIG_INT, 32'd0,  "tmr_int_not_yet");
    push(t + 22, SIG_INT, 32'd2,  "tmr_int_req");
    push(t + 24, SIG_MIP, 32'h0,  "tmr_mip_drop");
    push(t + 24, SIG_INT, 32'd2,  "tmr_int_held");
    push(t + 26, SIG_INT, 32'd0,  "tmr_int_acked");
    push(t + 26, SIG_HAND, 32'd1, "tmr_hand");
    wait_cyc(t + 1); bus.tmr_addr = 2'd0; bus.tmr_wdata = 32'd20;
    wait_cyc(t + 2); bus.tmr_addr = 2'd1; bus.tmr_wdata = 32'd0;
    wait_cyc(t + 3); bus.tmr_wr = 1'b0;   bus.tmr_addr = 2'd2;
    wait_cyc(t + 23); bus.tmr_wr = 1'b1;  bus.tmr_addr = 2'd1; bus.tmr_wdata = 32'd1;
    wait_cyc(t + 24); bus.tmr_wr = 1'b0;
    wait_cyc(t + 25); bus.epc_taken = 1'b1;
    wait_cyc(t + 26); bus.epc_taken = 1'b0;
    wait_cyc(t + 27); bus.is_mret = 1'b1;
    wait_cyc(t + 28); bus.is_mret = 1'b0;
    wait_cyc(t + 30);

    // Priority: both pending -> external first, timer after the mret
    t = cyc;
    bus.mie_mtie  = 1'b0;
    bus.tmr_wr    = 1'b1;
    bus.tmr_addr  = 2'd1;
    bus.tmr_wdata = 32'd0;
    ext_irq       = 1'b1;
    push(t + 3,  SIG_MIP, 32'h880, "prio_both_pending");
    push(t + 4,  SIG_INT, 32'd1,   "prio_ext_first");
    push(t + 6,  SIG_INT, 32'd0,   "prio_ext_acked");
    push(t + 6,  SIG_MIP, 32'h80,  "prio_timer_left");
    push(t + 8,  SIG_INT, 32'd0,   "prio_mret_idle");
    push(t + 9,  SIG_INT, 32'd2,   "prio_timer_second");
    push(t + 10, SIG_HAND, 32'd1,  "prio_timer_hand");
    push(t + 13, SIG_INT, 32'd0,   "prio_masked_idle");
    wait_cyc(t + 1);  bus.tmr_wr = 1'b0; ext_irq = 1'b0;
    wait_cyc(t + 3);  bus.mie_mtie = 1'b1;
    wait_cyc(t + 5);  bus.epc_taken = 1'b1;
    wait_cyc(t + 6);  bus.epc_taken = 1'b0;
    wait_cyc(t + 7);  bus.is_mret = 1'b1;
    wait_cyc(t + 8);  bus.is_mret = 1'b0;
    wait_cyc(t + 9);  bus.epc_taken = 1'b1;
    wait_cyc(t + 10); bus.epc_taken = 1'b0; bus.mie_mtie = 1'b0;
    wait_cyc(t + 11); bus.is_mret = 1'b1;
    wait_cyc(t + 12); bus.is_mret = 1'b0;
    wait_cyc(t + 14);

    // mtime wrap from all-ones
    t = cyc;
    bus.tmr_wr    = 1'b1;
    bus.tmr_addr  = 2'd2;
    bus.tmr_wdata = 32'hFFFF_FFFF;
    push(t + 2, SIG_RD, 32'hFFFF_FFFF, "wrap_hi_ones");
    push(t + 3, SIG_RD, 32'd0,         "wrap_hi_zero");
    push(t + 4, SIG_RD, 32'd1,         "wrap_lo_one");
    wait_cyc(t + 1); bus.tmr_addr = 2'd3;
    wait_cyc(t + 2); bus.tmr_wr = 1'b0;
    wait_cyc(t + 4); bus.tmr_addr = 2'd2;
    wait_cyc(t + 6);
`else
    // Timer removed: writes ignored, reads zero, no timer request
    t = cyc;
    bus.mie_mtie  = 1'b1;
    bus.tmr_wr    = 1'b1;
    bus.tmr_addr  = 2'd0;
    bus.tmr_wdata = 32'd0;
    push(t + 2, SIG_RD,  32'd0, "notmr_rd_cmp");
    push(t + 3, SIG_RD,  32'd0, "notmr_rd_mtime");
    push(t + 4, SIG_INT, 32'd0, "notmr_int");
    push(t + 4, SIG_MIP, 32'd0, "notmr_mip");
    push(t + 6, SIG_INT, 32'd0, "notmr_int_late");
    wait_cyc(t + 1); bus.tmr_addr = 2'd1;
    wait_cyc(t + 2); bus.tmr_wr = 1'b0; bus.tmr_addr = 2'd0;
    wait_cyc(t + 3); bus.tmr_addr = 2'd2;
    wait_cyc(t + 6); bus.mie_mtie = 1'b0;
    wait_cyc(t + 8);
`endif

    // Reset while a request is outstanding
    t = cyc;
    ext_irq = 1'b1;
    push(t + 4, SIG_INT,  32'd1, "rreq_int_req");
    push(t + 6, SIG_INT,  32'd0, "rreq_int_dropped");
    push(t + 6, SIG_HAND, 32'd0, "rreq_hand");
    push(t + 6, SIG_MIP,  32'd0, "rreq_mip");
`ifdef IRQ_TIMER_EN
    push(t + 6, SIG_RD, 32'hFFFF_FFFF, "rreq_cmp_lo");
    push(t + 7, SIG_RD, 32'hFFFF_FFFF, "rreq_cmp_hi");
`else
    push(t + 6, SIG_RD, 32'd0, "rreq_rd0");
    push(t + 7, SIG_RD, 32'd0, "rreq_rd1");
`endif
    push(t + 10, SIG_INT, 32'd0, "rreq_no_rereq");
    wait_cyc(t + 1); ext_irq = 1'b0;
    wait_cyc(t + 5); reset = 1'b1; bus.tmr_addr = 2'd0;
    wait_cyc(t + 7); bus.tmr_addr = 2'd1;
    wait_cyc(t + 8); reset = 1'b0;
    wait_cyc(t + 13);

    checks = checks + 1;
    if (bus.interrupt !== 2'b00) begin
      errors = errors + 1;
      $display("FAIL post_reset_int: got %0h expected 0", bus.interrupt);
    end
    checks = checks + 1;
    if (bus.in_handler !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL post_reset_hand: got %0h expected 0", bus.in_handler);
    end
    checks = checks + 1;
    if (bus.mip !== 32'd0) begin
      errors = errors + 1;
      $display("FAIL post_reset_mip: got %0h expected 0", bus.mip);
    end

    // Any expectation never reached is a failure
    while (sb_q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: got unchecked expected check at cycle %0d", sb_q[0].name, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
